// File: rtl/error_loc_eval_pkg.sv
// Shared definitions for the error-locator evaluation stage and the BM stage
// that feeds it: default field/code parameters and the evaluator FSM encoding.
package error_loc_eval_pkg;

    localparam int          M_DEFAULT    = 13;
    localparam int          T_DEFAULT    = 119;
    localparam int          N_DEFAULT    = 6960;
    localparam logic [12:0] POLY_DEFAULT = 13'b0000000011011;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EVAL  = 3'd3,
        EMIT  = 3'd4,
        FIN   = 3'd5
    } eval_state_e;

endpackage

// File: rtl/error_loc_eval_gf_mul.sv
// Combinational GF(2^m) multiplier: MSB-first shift-and-add with the
// reduction folded into every shift, so no wide intermediate product exists.
module gf_mul
    import error_loc_eval_pkg::*;
#(
    parameter int         m    = M_DEFAULT,
    parameter logic [m-1:0] poly = POLY_DEFAULT[m-1:0]
) (
    input  logic [m-1:0] a_i,
    input  logic [m-1:0] b_i,
    output logic [m-1:0] p_o
);

    logic [m-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = m - 1; i >= 0; i--) begin
            acc = {acc[m-2:0], 1'b0} ^ (acc[m-1] ? poly : '0);
            if (b_i[i]) begin
                acc = acc ^ a_i;
            end
        end
        p_o = acc;
    end

endmodule

// File: rtl/error_loc_eval.sv
// Chien-style error-locator evaluator: for every support element alpha_k it
// evaluates sigma(alpha_k) by Horner's rule and reports whether it is a root.
module error_loc_eval
    import error_loc_eval_pkg::*;
#(
    parameter int           m    = M_DEFAULT,
    parameter int           t    = T_DEFAULT,
    parameter int           n    = N_DEFAULT,
    parameter logic [m-1:0] poly = POLY_DEFAULT[m-1:0],
    localparam int          AW   = (n > 1) ? $clog2(n) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [m*(t+1)-1:0] error_loc_poly,
    output logic             supp_rd_en,
    output logic [AW-1:0]    supp_rd_addr,
    input  logic [m-1:0]     supp_dout,
    output logic             err_valid,
    output logic             err_bit,
    output logic [AW-1:0]    err_addr,
    output logic             busy,
    output logic             done
);

    localparam int JW = (t > 1) ? $clog2(t) : 1;
    localparam int PW = m * (t + 1);

    eval_state_e     state_q, state_d;
    logic [PW-1:0]   poly_q, poly_d;
    logic [AW-1:0]   k_q, k_d;
    logic [m-1:0]    alpha_q, alpha_d;
    logic [m-1:0]    acc_q, acc_d;
    logic [JW-1:0]   j_q, j_d;
    logic [m-1:0]    prod;
    logic [m-1:0]    coef_j;

    gf_mul #(
        .m    (m),
        .poly (poly)
    ) u_gf_mul (
        .a_i (acc_q),
        .b_i (alpha_q),
        .p_o (prod)
    );

    assign coef_j = poly_q[int'(j_q) * m +: m];
    assign busy   = (state_q != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            poly_q  <= '0;
            k_q     <= '0;
            alpha_q <= '0;
            acc_q   <= '0;
            j_q     <= '0;
        end else begin
            state_q <= state_d;
            poly_q  <= poly_d;
            k_q     <= k_d;
            alpha_q <= alpha_d;
            acc_q   <= acc_d;
            j_q     <= j_d;
        end
    end

    // Outputs are decoded purely from the state register so reset clears
    // them immediately and nothing moves until a start is accepted.
    always_comb begin
        state_d      = state_q;
        poly_d       = poly_q;
        k_d          = k_q;
        alpha_d      = alpha_q;
        acc_d        = acc_q;
        j_d          = j_q;
        supp_rd_en   = 1'b0;
        supp_rd_addr = '0;
        err_valid    = 1'b0;
        err_bit      = 1'b0;
        err_addr     = '0;
        done         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    poly_d  = error_loc_poly;
                    k_d     = '0;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                supp_rd_en   = 1'b1;
                supp_rd_addr = k_q;
                state_d      = LOAD;
            end
            LOAD: begin
                alpha_d = supp_dout;
                acc_d   = poly_q[t*m +: m];
                j_d     = JW'(t - 1);
                state_d = EVAL;
            end
            EVAL: begin
                acc_d = prod ^ coef_j;
                if (j_q == '0) begin
                    state_d = EMIT;
                end else begin
                    j_d = j_q - 1'b1;
                end
            end
            EMIT: begin
                err_valid = 1'b1;
                err_bit   = (acc_q == '0);
                err_addr  = k_q;
                if (k_q == AW'(n - 1)) begin
                    state_d = FIN;
                end else begin
                    k_d     = k_q + 1'b1;
                    state_d = FETCH;
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
